// File: rtl/serial_pattern_sequencer.sv
// Drives a WIDTH-bit pattern MSB-first into a serial Mealy detector and
// collects the detector's z response bits along with their population count.
module serial_pattern_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           z_in,
  output logic                           x_out,
  output logic                           det_reset_n,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH-1:0]               z_capture,
  output logic [$clog2(WIDTH+1)-1:0]     z_count
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned CNTW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [CNTW-1:0]   bit_cnt;

  // x_out is registered one edge ahead, so it always mirrors the MSB of the
  // shift register as it stands during the SHIFT cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      x_out       <= 1'b0;
      det_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      z_capture   <= '0;
      z_count     <= '0;
    end else begin
      x_out       <= 1'b0;
      det_reset_n <= 1'b1;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg        <= data_in;
            bit_cnt     <= '0;
            state       <= CLEAR;
            det_reset_n <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= SHIFT;
          z_capture <= '0;
          z_count   <= '0;
          x_out     <= sreg[WIDTH-1];
        end
        SHIFT: begin
          sreg      <= {sreg[WIDTH-2:0], 1'b0};
          z_capture <= {z_capture[WIDTH-2:0], z_in};
          z_count   <= z_count + CW'(z_in);
          bit_cnt   <= bit_cnt + CNTW'(1);
          if (bit_cnt == CNTW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            x_out <= sreg[WIDTH-2];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_pattern_sequencer.md
SERIAL_PATTERN_SEQUENCER -- requirements
Module: serial_pattern_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, number of pattern bits driven per run (legal 2..16).
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a run; sampled only in IDLE.
REQ-005 Port: data_in  input  WIDTH  pattern to drive; captured on the accepting edge.
REQ-006 Port: z_in  input  1  serial Mealy-detector output; combinationally responds to x_out in the same cycle.
REQ-007 Port: x_out  output  1  serial stimulus bit to the detector.
REQ-008 Port: det_reset_n  output  1  active-low reset to the detector.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: z_capture  output  WIDTH  collected z_in bits of the last run.
REQ-012 Port: z_count  output  clog2(WIDTH+1)  number of 1s in z_capture.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE; encoding is free.
REQ-014 IDLE: start=1 -> load data_in into the shift register, clear the bit counter, go to CLEAR; start=0 -> stay.
REQ-015 CLEAR: one cycle; det_reset_n=0; z_capture and z_count cleared on exit; next state SHIFT.
REQ-016 SHIFT: x_out SHALL equal the shift-register MSB, so bits go out MSB first, one per cycle.
REQ-017 SHIFT, each edge: shift register left by 1; z_capture <= {z_capture[WIDTH-2:0], z_in}; z_count += z_in; bit counter += 1.
REQ-018 SHIFT lasts exactly WIDTH cycles; after the edge consuming bit WIDTH-1, go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-020 Timing: start accepted at edge E0 -> CLEAR in cycle 1, SHIFT in cycles 2..WIDTH+1, done high in cycle WIDTH+2, busy low from cycle WIDTH+3.
REQ-021 start in CLEAR, SHIFT or DONE SHALL be ignored; start held high SHALL launch a new run on the first IDLE cycle after DONE.
REQ-022 data_in changes after acceptance SHALL NOT affect the running pattern.
REQ-023 x_out SHALL be 0 outside SHIFT; det_reset_n SHALL be 1 outside CLEAR, except during reset.
REQ-024 z_capture and z_count SHALL hold the last run's result from DONE until the next CLEAR.
REQ-025 z_count SHALL never wrap; its maximum is WIDTH.

Reset
REQ-026 reset=0 SHALL immediately force IDLE and clear the shift register, bit counter, z_capture, z_count, done and busy, regardless of clock.
REQ-027 det_reset_n SHALL be 0 while reset=0, so the detector is reset with the sequencer.
REQ-028 reset asserted mid-run SHALL abort the run with no done pulse; results are cleared.

Verification
REQ-029 reset low during SHIFT -> x_out=0, busy=0, done=0, z_capture=0, z_count=0, det_reset_n=0 immediately; FSM in IDLE after release.
REQ-030 WIDTH=8, data_in=8'hA5, z_in tied to x_out, one start pulse -> x_out=1,0,1,0,0,1,0,1 over cycles 2..9; done in cycle 10; z_capture=8'hA5; z_count=4.
REQ-031 data_in=8'hFF, z_in tied 0 -> z_capture=8'h00, z_count=0; det_reset_n low only in cycle 1.
REQ-032 z_in tied 1, any pattern -> z_capture=8'hFF, z_count=8 with no wrap.
REQ-033 start held high, data_in changed to 8'h3C during run 1 (launched with 8'hA5) -> run 1 drives A5 unchanged; run 2 starts the cycle after DONE with 3C; no extra start is accepted mid-run.
REQ-034 Results persistence: after run with 8'hA5, idle 20 cycles -> z_capture=8'hA5, z_count=4, busy=0 held.
